mult_div_unit: RTL and testbench

- Iterative multiply/divide unit directly downstream of the register bank.
- Consumes the two read-port operands (DataReg1 → OpA, DataReg2 → OpB) when the decoder issues a start.
- Holds the 64-bit result in internal Hi/Lo registers; the writeback path reads them and returns them to the register bank's Data input.
- Replaces a single-cycle combinational multiplier/divider with a fixed 34-cycle shift-add / restoring-divide sequence.

---
 rtl/mult_div_unit.sv | 127 ++++++++++++
 tb/tb_mult_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: 32-step shift-add multiply or restoring divide,
// one post-step cycle for sign fix-up, then a one-cycle FIN with Done.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             HiWe,
    input  logic             LoWe,
    input  logic [WIDTH-1:0] WrData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t               r_state, w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_post;
    logic [1:0]           r_op;
    logic                 r_neg, r_dneg, r_divz;
    logic [WIDTH-1:0]     r_mcand, r_opa, r_hi, r_lo;
    logic [2*WIDTH-1:0]   r_acc;

    logic [WIDTH-1:0]     w_absa, w_absb;
    logic [WIDTH:0]       w_msum, w_dsh, w_ddiff;
    logic [2*WIDTH-1:0]   w_step, w_prod;
    logic [WIDTH-1:0]     w_quo, w_rem;

    // Op[0] marks the signed variants, Op[1] marks divide
    assign w_absa = (Op[0] && OpA[WIDTH-1]) ? -OpA : OpA;
    assign w_absb = (Op[0] && OpB[WIDTH-1]) ? -OpB : OpB;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_msum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    assign w_dsh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_ddiff = w_dsh - {1'b0, r_mcand};
    assign w_step  = !r_op[1]    ? {w_msum, r_acc[WIDTH-1:1]} :
                     w_ddiff[WIDTH] ? {w_dsh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0} :
                                      {w_ddiff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = (r_op == 2'b01 && r_neg)  ? -r_acc : r_acc;
    assign w_quo  = (r_op == 2'b11 && r_neg)  ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = (r_op == 2'b11 && r_dneg) ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (Start) w_next = CALC;
            CALC:    if (r_post) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state != IDLE);
        Done = (r_state == FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_post  <= 1'b0;
            r_op    <= 2'b00;
            r_neg   <= 1'b0;
            r_dneg  <= 1'b0;
            r_divz  <= 1'b0;
            r_mcand <= '0;
            r_opa   <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_cnt   <= '0;
                        r_post  <= 1'b0;
                        r_op    <= Op;
                        r_neg   <= Op[0] & (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        r_dneg  <= Op[0] & OpA[WIDTH-1];
                        r_divz  <= (OpB == '0);
                        r_opa   <= OpA;
                        r_mcand <= Op[1] ? w_absb : w_absa;
                        r_acc   <= Op[1] ? {{WIDTH{1'b0}}, w_absa} : {{WIDTH{1'b0}}, w_absb};
                    end else begin
                        if (HiWe) r_hi <= WrData;
                        if (LoWe) r_lo <= WrData;
                    end
                end
                CALC: begin
                    if (!r_post) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CNT_W'(WIDTH-1)) r_post <= 1'b1;
                    end else if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod;
                    end else if (r_divz) begin
                        // divide by zero: all-ones quotient, dividend passed through untouched
                        r_hi <= r_opa;
                        r_lo <= {WIDTH{1'b1}};
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Hi = r_hi;
    assign Lo = r_lo;
endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: countdown/arithmetic reference model, per-cycle compare,
// directed literal cases plus randomized operations.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [31:0] OpA = '0, OpB = '0, WrData = '0;
    logic        HiWe = 1'b0, LoWe = 1'b0;
    logic        Busy, Done;
    logic [31:0] Hi, Lo;

    int n_chk = 0;
    int n_fail = 0;
    bit chk_en = 0;

    mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .OpA(OpA), .OpB(OpB),
        .HiWe(HiWe), .LoWe(LoWe), .WrData(WrData),
        .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition
    function automatic logic [63:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb, q, rm;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: r = {32'b0, a} * {32'b0, b};
            2'd1: r = sa * sb;
            2'd2: r = (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            default: begin
                if (b == 0) r = {a, 32'hFFFFFFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Model: m_cnt counts down remaining busy cycles; 1 means the Done cycle
    int          m_cnt;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (m_cnt == 0) begin
            if (Start) begin
                m_cnt  <= 34;
                m_pend <= ref_res(Op, OpA, OpB);
            end else begin
                if (HiWe) m_hi <= WrData;
                if (LoWe) m_lo <= WrData;
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) {m_hi, m_lo} <= m_pend;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, Busy}, {31'b0, m_cnt != 0});
            chk("done", {31'b0, Done}, {31'b0, m_cnt == 1});
            chk("hi", Hi, m_hi);
            chk("lo", Lo, m_lo);
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        Op = op; OpA = a; OpB = b; Start = 1'b1;
        HiWe = 1'($urandom_range(0, 1)); WrData = $urandom;
        @(posedge clk); #1;
        Start = 1'b0; HiWe = 1'b0;
        OpA = $urandom; OpB = $urandom; Op = 2'($urandom);
    endtask

    // Waits for Done; n0 = edges already elapsed since the Start edge
    task automatic wait_done(input int n0);
        int n;
        bit seen;
        n = n0;
        seen = 0;
        while (!seen && n < 80) begin
            @(posedge clk); #1;
            n++;
            if (Done) seen = 1;
        end
        chk("done_latency", n, 33);
    endtask

    task automatic finish_op();
        @(posedge clk); #1;
        chk("done_pulse", {31'b0, Done}, 32'd0);
    endtask

    task automatic run_lit(input string nm, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        start_op(op, a, b);
        wait_done(0);
        chk({nm, "_hi"}, Hi, eh);
        chk({nm, "_lo"}, Lo, el);
        finish_op();
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h80000000;
            3: return 32'hFFFFFFFF;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        rst_n = 1'b1;
        chk_en = 1;

        start_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("busy_rise", {31'b0, Busy}, 32'd1);
        wait_done(0);
        chk("multu_max_hi", Hi, 32'hFFFFFFFE);
        chk("multu_max_lo", Lo, 32'h00000001);
        finish_op();

        run_lit("mult_neg", 2'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_lit("multu_same", 2'd0, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        run_lit("div_neg", 2'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_lit("divu", 2'd2, 32'd100, 32'd7, 32'd2, 32'd14);
        run_lit("divu_zero", 2'd2, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF);
        run_lit("div_zero", 2'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        run_lit("div_ovf", 2'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);

        // Start and HiWe during an operation must be ignored
        start_op(2'd0, 32'h0000FFFF, 32'h00010001);
        repeat (9) @(posedge clk);
        #1;
        Start = 1'b1; Op = 2'd2; OpA = 32'd50; OpB = 32'd5;
        HiWe = 1'b1; WrData = 32'hDEADBEEF;
        @(posedge clk); #1;
        Start = 1'b0; HiWe = 1'b0;
        wait_done(10);
        chk("midop_hi", Hi, 32'h00000000);
        chk("midop_lo", Lo, 32'hFFFFFFFF);
        finish_op();

        HiWe = 1'b1; WrData = 32'hDEADBEEF;
        @(posedge clk); #1;
        HiWe = 1'b0;
        chk("mthi_hi", Hi, 32'hDEADBEEF);
        chk("mthi_lo", Lo, 32'hFFFFFFFF);
        HiWe = 1'b1; LoWe = 1'b1; WrData = 32'h5A5A5A5A;
        @(posedge clk); #1;
        HiWe = 1'b0; LoWe = 1'b0;
        chk("mthilo_hi", Hi, 32'h5A5A5A5A);
        chk("mthilo_lo", Lo, 32'h5A5A5A5A);

        // Reset mid-operation discards everything immediately
        start_op(2'd3, 32'hFFFFFF9C, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, Busy}, 32'd0);
        chk("arst_done", {31'b0, Done}, 32'd0);
        chk("arst_hi", Hi, 32'd0);
        chk("arst_lo", Lo, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_lit("post_rst", 2'd0, 32'd3, 32'd5, 32'd0, 32'd15);

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  op;
            logic [31:0] a, b;
            op = 2'($urandom_range(0, 3));
            a = pick();
            b = pick();
            if ($urandom_range(0, 3) == 0) begin
                HiWe = 1'($urandom_range(0, 1));
                LoWe = 1'($urandom_range(0, 1));
                WrData = $urandom;
                @(posedge clk); #1;
                HiWe = 1'b0; LoWe = 1'b0;
            end
            start_op(op, a, b);
            wait_done(0);
            finish_op();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
